// File: rtl/xs3_pkg.sv
// Shared constants and types for the XS-3 digit accumulator.
// XS-3 codes carry each decimal digit offset by three, so legal codes span 0011..1100.
package xs3_pkg;

  localparam logic [3:0] XS3_OFFSET = 4'd3;
  localparam logic [3:0] XS3_MIN    = 4'b0011;
  localparam logic [3:0] XS3_MAX    = 4'b1100;
  localparam logic [3:0] CNT_MAX    = 4'hF;

  typedef enum logic [0:0] {
    ACCUM,
    DONE
  } state_e;

  // Digit counter increment that sticks at CNT_MAX.
  function automatic logic [3:0] cnt_sat_inc(input logic [3:0] c);
    return (c == CNT_MAX) ? c : c + 4'd1;
  endfunction

endpackage

// File: rtl/xs3_digit_dec.sv
// Combinational XS-3 to decimal digit decoder with a legality flag.
// The decoded value of an illegal code is meaningless; callers must honour the legal flag.
module xs3_digit_dec
  import xs3_pkg::*;
(
  input  logic [3:0] xs,
  output logic [3:0] d,
  output logic       legal
);

  assign d     = xs - XS3_OFFSET;
  assign legal = (xs >= XS3_MIN) && (xs <= XS3_MAX);

endmodule

// File: rtl/xs3_dec_accum.sv
// Accumulates an MSD-first stream of XS-3 digits into a binary value per frame.
// The result is held in registers and handed off over a valid/ready handshake.
module xs3_dec_accum
  import xs3_pkg::*;
#(
  parameter int unsigned NDIG  = 4,
  parameter int unsigned OUT_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_digit,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_bin,
  output logic             out_err,
  output logic [3:0]       out_ndig
);

  state_e             state_q;
  logic [OUT_W-1:0]   acc_q, acc_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [3:0]         dig_val;
  logic               dig_legal;
  logic               too_many;
  logic               accept;

  xs3_digit_dec u_dec (
    .xs    (in_digit),
    .d     (dig_val),
    .legal (dig_legal)
  );

  assign in_ready = (state_q == ACCUM);
  assign accept   = in_valid && in_ready;

  always_comb begin
    acc_d    = (acc_q << 3) + (acc_q << 1) + OUT_W'(dig_val);
    cnt_d    = cnt_sat_inc(cnt_q);
    // Accepting this digit makes the count exceed NDIG.
    too_many = (32'(cnt_q) >= NDIG);
    err_d    = err_q || !dig_legal || too_many;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      out_valid <= 1'b0;
      out_bin   <= '0;
      out_err   <= 1'b0;
      out_ndig  <= '0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (accept) begin
            if (in_last) begin
              out_valid <= 1'b1;
              out_bin   <= err_d ? '0 : acc_d;
              out_err   <= err_d;
              out_ndig  <= cnt_d;
              acc_q     <= '0;
              cnt_q     <= '0;
              err_q     <= 1'b0;
              state_q   <= DONE;
            end else begin
              acc_q <= acc_d;
              cnt_q <= cnt_d;
              err_q <= err_d;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= ACCUM;
          end
        end
      endcase
    end
  end

  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=>
      (out_valid && $stable(out_bin) && $stable(out_err) && $stable(out_ndig)));

  a_valid_in_done: assert property (@(posedge clk) disable iff (rst)
    out_valid == (state_q == DONE));

endmodule

// File: tb/tb_xs3_dec_accum.sv
// Scoreboard bench for xs3_dec_accum: expected results are modelled per frame as digits are sent.
module tb_xs3_dec_accum;

  localparam int unsigned NDIG  = 4;
  localparam int unsigned OUT_W = 14;

  logic             clk       = 1'b0;
  logic             rst       = 1'b1;
  logic             in_valid  = 1'b0;
  logic [3:0]       in_digit  = 4'd0;
  logic             in_last   = 1'b0;
  logic             out_ready = 1'b1;
  logic             in_ready;
  logic             out_valid;
  logic [OUT_W-1:0] out_bin;
  logic             out_err;
  logic [3:0]       out_ndig;

  typedef struct packed {
    logic [OUT_W-1:0] bin;
    logic             err;
    logic [3:0]       ndig;
  } res_t;

  res_t       exp_q[$];
  logic [3:0] frame_q[$];
  res_t       got, exp_r, snap;
  int         got_lat;
  bit         got_to;
  int         n_checks = 0;
  int         n_errors = 0;

  xs3_dec_accum #(
    .NDIG  (NDIG),
    .OUT_W (OUT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_digit  (in_digit),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bin   (out_bin),
    .out_err   (out_err),
    .out_ndig  (out_ndig)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Decimal reference model of the frame currently in frame_q.
  function automatic res_t model();
    res_t        r;
    int unsigned val = 0;
    bit          e   = 1'b0;
    int          n   = 0;
    foreach (frame_q[i]) begin
      if (frame_q[i] < 4'd3 || frame_q[i] > 4'd12) e = 1'b1;
      else val = val * 10 + int'(frame_q[i]) - 3;
      n++;
    end
    if (n > int'(NDIG)) e = 1'b1;
    r.bin  = e ? '0 : OUT_W'(val);
    r.err  = e;
    r.ndig = (n > 15) ? 4'd15 : 4'(n);
    return r;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL in_ready_timeout got in_ready=%0b need 1", in_ready);
    end
  endtask

  // Sends frame_q starting at a falling edge; ends at the falling edge after the final accept.
  task automatic send_digits(input bit with_last);
    if (with_last) exp_q.push_back(model());
    for (int i = 0; i < frame_q.size(); i++) begin
      in_valid = 1'b1;
      in_digit = frame_q[i];
      in_last  = with_last && (i == frame_q.size() - 1);
      wait_ready();
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic collect();
    got_lat = 0;
    while (!out_valid && got_lat < 20) begin
      @(negedge clk);
      got_lat++;
    end
    got_to   = !out_valid;
    got.bin  = out_bin;
    got.err  = out_err;
    got.ndig = out_ndig;
    exp_r    = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    if (out_ready) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({out_valid, out_bin, out_err, out_ndig, in_ready} !== {1'b0, {OUT_W{1'b0}}, 1'b0, 4'd0, 1'b1}) begin
      n_errors++;
      $display("FAIL reset_state got v=%0b bin=%0d err=%0b ndig=%0d rdy=%0b need 0 0 0 0 1",
               out_valid, out_bin, out_err, out_ndig, in_ready);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    frame_q = '{4'b0100, 4'b0101, 4'b0110, 4'b0111};
    send_digits(1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || out_bin !== 14'd1234) begin
      n_errors++;
      $display("FAIL basic_latency got v=%0b bin=%0d need v=1 bin=1234", out_valid, out_bin);
    end
    collect();
    n_checks++;
    if (got_to || got !== exp_r) begin
      n_errors++;
      $display("FAIL basic_result got bin=%0d err=%0b ndig=%0d need bin=%0d err=%0b ndig=%0d",
               got.bin, got.err, got.ndig, exp_r.bin, exp_r.err, exp_r.ndig);
    end
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL basic_release got v=%0b rdy=%0b need v=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_single();
    logic [3:0] codes [2] = '{4'b1100, 4'b0011};
    for (int k = 0; k < 2; k++) begin
      frame_q = '{codes[k]};
      send_digits(1'b1);
      collect();
      n_checks++;
      if (got_to || got !== exp_r || got_lat != 0) begin
        n_errors++;
        $display("FAIL single_%0d got bin=%0d err=%0b ndig=%0d lat=%0d need bin=%0d err=%0b ndig=%0d lat=0",
                 k, got.bin, got.err, got.ndig, got_lat, exp_r.bin, exp_r.err, exp_r.ndig);
      end
    end
  endtask

  task automatic test_illegal();
    frame_q = '{4'b0100, 4'b0001, 4'b0101};
    send_digits(1'b1);
    collect();
    n_checks++;
    if (got_to || got !== exp_r || got.err !== 1'b1) begin
      n_errors++;
      $display("FAIL illegal_digit got bin=%0d err=%0b ndig=%0d need bin=%0d err=%0b ndig=%0d",
               got.bin, got.err, got.ndig, exp_r.bin, exp_r.err, exp_r.ndig);
    end
    frame_q = '{4'b0101};
    send_digits(1'b1);
    collect();
    n_checks++;
    if (got_to || got !== exp_r) begin
      n_errors++;
      $display("FAIL illegal_no_carry got bin=%0d err=%0b ndig=%0d need bin=%0d err=%0b ndig=%0d",
               got.bin, got.err, got.ndig, exp_r.bin, exp_r.err, exp_r.ndig);
    end
  endtask

  task automatic test_overlong();
    int lens [2] = '{5, 17};
    for (int k = 0; k < 2; k++) begin
      frame_q.delete();
      for (int i = 0; i < lens[k]; i++) frame_q.push_back(4'b0100);
      send_digits(1'b1);
      collect();
      n_checks++;
      if (got_to || got !== exp_r) begin
        n_errors++;
        $display("FAIL overlong_%0d got bin=%0d err=%0b ndig=%0d need bin=%0d err=%0b ndig=%0d",
                 lens[k], got.bin, got.err, got.ndig, exp_r.bin, exp_r.err, exp_r.ndig);
      end
    end
    frame_q = '{4'b1100, 4'b1100, 4'b1100, 4'b1100};
    send_digits(1'b1);
    collect();
    n_checks++;
    if (got_to || got !== exp_r || got.bin !== 14'd9999) begin
      n_errors++;
      $display("FAIL max_legal got bin=%0d err=%0b ndig=%0d need bin=9999 err=0 ndig=4",
               got.bin, got.err, got.ndig);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    frame_q   = '{4'b0100, 4'b0101, 4'b0110, 4'b0111};
    send_digits(1'b1);
    exp_r     = exp_q.pop_front();
    snap.bin  = out_bin;
    snap.err  = out_err;
    snap.ndig = out_ndig;
    n_checks++;
    if (out_valid !== 1'b1 || snap !== exp_r) begin
      n_errors++;
      $display("FAIL bp_result got v=%0b bin=%0d err=%0b ndig=%0d need v=1 bin=%0d err=%0b ndig=%0d",
               out_valid, snap.bin, snap.err, snap.ndig, exp_r.bin, exp_r.err, exp_r.ndig);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {out_bin, out_err, out_ndig} !== snap) begin
        n_errors++;
        $display("FAIL bp_hold_%0d got v=%0b rdy=%0b bin=%0d need v=1 rdy=0 bin=%0d",
                 c, out_valid, in_ready, out_bin, snap.bin);
      end
    end
    out_ready = 1'b1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_handshake_ready got rdy=%0b need 0", in_ready);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_after got v=%0b rdy=%0b need v=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_async_reset();
    // Reset while a result is pending in DONE.
    out_ready = 1'b0;
    frame_q   = '{4'b1100};
    send_digits(1'b1);
    void'(exp_q.pop_front());
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, out_bin, out_err, out_ndig, in_ready} !== {1'b0, {OUT_W{1'b0}}, 1'b0, 4'd0, 1'b1}) begin
      n_errors++;
      $display("FAIL rst_done got v=%0b bin=%0d err=%0b ndig=%0d rdy=%0b need 0 0 0 0 1",
               out_valid, out_bin, out_err, out_ndig, in_ready);
    end
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    // Reset mid-frame after two accepted digits.
    frame_q = '{4'b0100, 4'b0101};
    send_digits(1'b0);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, out_bin, out_err, out_ndig, in_ready} !== {1'b0, {OUT_W{1'b0}}, 1'b0, 4'd0, 1'b1}) begin
      n_errors++;
      $display("FAIL rst_mid_frame got v=%0b bin=%0d err=%0b ndig=%0d rdy=%0b need 0 0 0 0 1",
               out_valid, out_bin, out_err, out_ndig, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL rst_no_result_%0d got v=%0b need 0", c, out_valid);
      end
    end
    frame_q = '{4'b0110};
    send_digits(1'b1);
    collect();
    n_checks++;
    if (got_to || got !== exp_r || got.bin !== 14'd3) begin
      n_errors++;
      $display("FAIL rst_next_frame got bin=%0d err=%0b ndig=%0d need bin=3 err=0 ndig=1",
               got.bin, got.err, got.ndig);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_illegal();
    test_overlong();
    test_backpressure();
    test_async_reset();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain got %0d left need 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/xs3_dec_accum.md
Name: xs3_dec_accum

Overview:
- Sequential consumer of XS-3 coded decimal digits, sitting directly downstream of the per-digit XS-3 code path.
- Accepts one XS-3 digit per cycle, most-significant digit first, over a valid/ready handshake.
- Decodes each digit to 0..9 and accumulates a multi-digit decimal number into a binary result.
- Presents the result with an error flag to the next stage over a second valid/ready handshake.

Parameters:
- NDIG, 4, maximum digits per frame (1..9).
- OUT_W, 14, result width; must be >= ceil(log2(10^NDIG)); 14 covers 9999.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_digit/in_last valid.
- in_ready  output  1  block accepts a digit this cycle.
- in_digit  input  4  XS-3 digit; legal range 0011..1100.
- in_last  input  1  marks final digit of a frame.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts result.
- out_bin  output  OUT_W  binary value of frame; 0 when out_err=1.
- out_err  output  1  frame contained an illegal digit or more than NDIG digits.
- out_ndig  output  4  number of digits accepted in the frame.

Behaviour:
- Reset (async assert, sync release): state=ACCUM; acc=0; cnt=0; err=0; out_valid=0; out_bin=0; out_err=0; out_ndig=0; in_ready=1.
- Digit accept: when in_valid && in_ready.
- Digit decode: d = in_digit - 3 (4-bit). The digit is illegal when in_digit < 0011 or in_digit > 1100.
- States: ACCUM and DONE.
- ACCUM, in_ready=1. On each accepted digit:
  - acc_next = (acc<<3) + (acc<<1) + d, truncated to OUT_W.
  - cnt increments, saturating at 15.
  - Sticky err is set if the digit is illegal, or if this digit would make cnt exceed NDIG. Accumulation continues regardless; its value is discarded when err is set.
- Accepted digit with in_last=1:
  - Transfer to DONE the next cycle.
  - out_bin = err_next ? 0 : acc_next; out_err = err_next; out_ndig = cnt+1 (saturating); out_valid=1.
  - Latency is 1 cycle from the last-digit accept to out_valid.
  - acc, cnt and err clear the same edge.
- DONE:
  - in_ready=0.
  - Outputs hold stable while out_valid && !out_ready, for any number of cycles.
  - On out_ready=1: out_valid=0 next cycle and return to ACCUM.
  - No bypass: in_ready stays 0 in the handshake cycle and rises the following cycle.
- in_valid=0 in ACCUM: no change; partial frame held indefinitely.
- Single-digit frame (first digit with in_last=1) is legal.
- Overflow: with cnt saturating, frames longer than 15 digits still report out_ndig=15 and out_err=1.
- Reset mid-frame or mid-DONE: partial accumulation and any pending result are discarded; no out_valid is produced for that frame.
- Outputs are registered; there is no combinational path from in_* to out_*.
- in_ready depends on state only.

Decomposition:
- Package xs3_pkg holds:
  - XS3_OFFSET = 4'd3, XS3_MIN = 4'b0011, XS3_MAX = 4'b1100.
  - State enum {ACCUM, DONE}.
- Sub-module xs3_digit_dec (combinational): in xs[3:0] -> out d[3:0], legal. Instantiated once.
- The top level holds the FSM, the accumulator with the x10 shift-add, and the counters.

Test Plan:
- Frame 0100,0101,0110,0111 (last on 4th), out_ready=1 -> out_bin=1234 (0x4D2), out_err=0, out_ndig=4, out_valid one cycle after 4th accept.
- Single digit 1100 with in_last -> out_bin=9, out_ndig=1. Then 0011 with in_last -> out_bin=0, out_err=0.
- Frame 0100,0001,0101 (0001 illegal) -> out_err=1, out_bin=0, out_ndig=3. Next frame 0101 last -> out_bin=2, out_err=0 (err not carried over).
- Five digits 0100 x5 with NDIG=4 -> out_err=1, out_bin=0, out_ndig=5. Max legal frame 1100 x4 -> out_bin=9999.
- Hold out_ready=0 for 3 cycles after result -> out_bin/out_err/out_ndig stable, in_ready=0 throughout. out_ready=1 -> out_valid=0 and in_ready=1 the next cycle; in_ready=0 in the handshake cycle.
- Accept 0100,0101, assert rst asynchronously mid-cycle -> all outputs 0 immediately and in_ready=1. Then 0110 last -> out_bin=3, out_ndig=1.
